// File: rtl/tm1638_frame_tx.sv
// tm1638_frame_tx: latches eight hex digits and serialises one TM1638 frame (cmd 0x40, 0xC0 + 16 data bytes, 0x88|brightness).
// Define TM_AUTO_REFRESH_EN to add a free-running refresh request every REFRESH_CYCLES system cycles.
module tm1638_frame_tx #(
  parameter int CLK_DIV        = 25,
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic        _50MHz_CLK,
  input  logic        rst,
  input  logic [31:0] digits,
  input  logic [2:0]  brightness,
  input  logic        update,
  output logic        busy,
  output logic        done,
  output logic        clk,
  output logic        stb,
  output logic        dio
);
  typedef enum logic [2:0] {IDLE, START, BIT_LO, BIT_HI, HOLD, GAP, DONE} state_t;
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  state_t      state_q, state_d;
  logic [7:0]  pre_q, pre_d, bit_q, bit_d;
  logic [1:0]  tx_q, tx_d;
  logic        pend_q, pend_d;
  logic [31:0] dig_q, dig_d;
  logic [2:0]  br_q, br_d;
  logic        refresh, req, start, tick, last_bit, cur_bit;
  logic [3:0]  code;
  logic [7:0]  seg_byte, t2_byte, cur_byte;

`ifdef TM_AUTO_REFRESH_EN
  localparam logic [31:0] REF_M1 = 32'(REFRESH_CYCLES - 1);
  logic [31:0] ref_q;
  always_ff @(posedge _50MHz_CLK or posedge rst)
    if (rst) ref_q <= '0;
    else ref_q <= (ref_q == REF_M1) ? '0 : ref_q + 32'd1;
  assign refresh = ref_q == REF_M1;
`else
  assign refresh = 1'b0;
`endif

  assign req      = update | refresh;
  assign start    = state_q == IDLE && (req || pend_q);
  assign tick     = pre_q == 8'd0;
  assign last_bit = bit_q == (tx_q == 2'd1 ? 8'd135 : 8'd7);

  // T2 byte n>=1 is address n-1; odd n is an even address carrying digit n[3:1]
  assign code     = dig_q[{bit_q[6:4], 2'b00} +: 4];
  assign t2_byte  = bit_q[7:3] == 5'd0 ? 8'hC0 : bit_q[3] ? seg_byte : 8'h00;
  assign cur_byte = tx_q == 2'd0 ? 8'h40 : tx_q == 2'd1 ? t2_byte : {5'b10001, br_q};
  assign cur_bit  = cur_byte[bit_q[2:0]];

  always_comb begin
    seg_byte = 8'h00;
    case (code)
      4'h0: seg_byte = 8'h3F;
      4'h1: seg_byte = 8'h06;
      4'h2: seg_byte = 8'h5B;
      4'h3: seg_byte = 8'h4F;
      4'h4: seg_byte = 8'h66;
      4'h5: seg_byte = 8'h6D;
      4'h6: seg_byte = 8'h7D;
      4'h7: seg_byte = 8'h07;
      4'h8: seg_byte = 8'h7F;
      4'h9: seg_byte = 8'h6F;
      4'hA: seg_byte = 8'h77;
      4'hB: seg_byte = 8'h7C;
      4'hC: seg_byte = 8'h39;
      4'hD: seg_byte = 8'h5E;
      4'hE: seg_byte = 8'h79;
      default: seg_byte = 8'h71;
    endcase
  end

  always_ff @(posedge _50MHz_CLK or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= DIV_M1;
      bit_q   <= '0;
      tx_q    <= '0;
      pend_q  <= 1'b0;
      dig_q   <= '0;
      br_q    <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      pend_q  <= pend_d;
      dig_q   <= dig_d;
      br_q    <= br_d;
    end

  // The final clk-high phase doubles as the end-of-transaction hold, so a transaction plus its gap is (2n+2)*D
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = START;
      START:   if (tick) state_d = BIT_LO;
      BIT_LO:  if (tick) state_d = last_bit ? HOLD : BIT_HI;
      BIT_HI:  if (tick) state_d = BIT_LO;
      HOLD:    if (tick) state_d = GAP;
      GAP:     if (tick) state_d = tx_q == 2'd2 ? DONE : START;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_d  = (state_q == IDLE || tick) ? DIV_M1 : pre_q - 8'd1;
    bit_d  = state_q == START ? 8'd0 : (state_q == BIT_HI && tick) ? bit_q + 8'd1 : bit_q;
    tx_d   = state_q == IDLE ? 2'd0 : (state_q == GAP && tick) ? tx_q + 2'd1 : tx_q;
    pend_d = state_q == IDLE ? 1'b0 : pend_q | req;
    dig_d  = start ? digits : dig_q;
    br_d   = start ? brightness : br_q;
  end

  always_comb begin
    busy = !(state_q inside {IDLE, DONE});
    done = state_q == DONE;
    clk  = state_q != BIT_LO;
    stb  = state_q inside {IDLE, GAP, DONE};
    dio  = state_q inside {BIT_LO, BIT_HI, HOLD} ? cur_bit : 1'b1;
  end
endmodule

// File: tb/tb_tm1638_frame_tx.sv
// tb_tm1638_frame_tx: scoreboard bench decoding the serial pins of tm1638_frame_tx (CLK_DIV=2).
module tb_tm1638_frame_tx;
  logic        sclk = 1'b0;
  logic        rst = 1'b0;
  logic        update = 1'b0;
  logic [31:0] digits = '0;
  logic [2:0]  brightness = '0;
  logic        busy, done, clk, stb, dio;

  tm1638_frame_tx #(.CLK_DIV(2)) dut (
    ._50MHz_CLK(sclk),
    .rst(rst),
    .digits(digits),
    .brightness(brightness),
    .update(update),
    .busy(busy),
    .done(done),
    .clk(clk),
    .stb(stb),
    .dio(dio)
  );

  always #10 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int viol = 0;
  logic [7:0] exp_b[$];
  int exp_d[$];

  logic [7:0] SEG [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] FA [19] = '{8'h40, 8'hC0, 8'h3F, 8'h00, 8'h06, 8'h00, 8'h5B, 8'h00, 8'h4F, 8'h00,
                          8'h66, 8'h00, 8'h6D, 8'h00, 8'h7D, 8'h00, 8'h07, 8'h00, 8'h8F};
  logic [7:0] FB [19] = '{8'h40, 8'hC0, 8'h7F, 8'h00, 8'h6F, 8'h00, 8'h77, 8'h00, 8'h7C, 8'h00,
                          8'h39, 8'h00, 8'h5E, 8'h00, 8'h79, 8'h00, 8'h71, 8'h00, 8'h8B};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_list(input logic [7:0] f [19], input int d);
    for (int i = 0; i < 19; i++) exp_b.push_back(f[i]);
    exp_d.push_back(d);
  endtask

  task automatic push_frame(input logic [31:0] dg, input logic [2:0] br, input int d);
    exp_b.push_back(8'h40);
    exp_b.push_back(8'hC0);
    for (int k = 0; k < 8; k++) begin
      exp_b.push_back(SEG[dg[4*k +: 4]]);
      exp_b.push_back(8'h00);
    end
    exp_b.push_back({5'b10001, br});
    exp_d.push_back(d);
  endtask

  task automatic pulse(input logic [31:0] dg, input logic [2:0] br, output int ucyc);
    @(negedge sclk);
    digits = dg;
    brightness = br;
    update = 1'b1;
    ucyc = cyc;
    @(negedge sclk);
    update = 1'b0;
    check("busy_after_update", busy, 1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sclk);
  endtask

  // Monitor: rebuilds bytes from the pins and scores them and the done pulse
  logic pclk = 1'b1, pstb = 1'b1, pdio = 1'b1;
  logic [7:0] acc = '0;
  int nb = 0;
  always @(negedge sclk) begin
    if (rst) nb = 0;
    else begin
      if (!stb && !pstb && clk && dio != pdio) viol++;
      if (!stb && !pclk && clk) begin
        acc = {dio, acc[7:1]};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte got %02h want none", acc);
          end else check("frame_byte", acc, exp_b.pop_front());
        end
      end
      if (done) begin
        check("busy_low_at_done", busy, 0);
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got cycle %0d want none", cyc);
        end else check("done_cycle", cyc, exp_d.pop_front());
      end
    end
    pclk = clk;
    pstb = stb;
    pdio = dio;
  end

  initial begin
    int u;
    #1 rst = 1'b1;
    #2;
    check("rst_clk", clk, 1);
    check("rst_stb", stb, 1);
    check("rst_dio", dio, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (3) @(negedge sclk);
    #2 rst = 1'b0;

    pulse(32'h76543210, 3'd7, u);
    push_list(FA, u + 621);
    wait_until(u + 630);

    pulse(32'hFEDCBA98, 3'd3, u);
    push_list(FB, u + 621);
    wait_until(u + 630);

    // Held update mid-frame and digit change: one extra frame with the new digits
    pulse(32'h00000000, 3'd0, u);
    push_frame(32'h00000000, 3'd0, u + 621);
    repeat (100) @(negedge sclk);
    digits = 32'h11111111;
    brightness = 3'd5;
    update = 1'b1;
    repeat (3) @(negedge sclk);
    update = 1'b0;
    push_frame(32'h11111111, 3'd5, u + 1243);
    wait_until(u + 1260);

    // Reset around T2 bit 50
    pulse(32'h89ABCDEF, 3'd2, u);
    push_frame(32'h89ABCDEF, 3'd2, u + 621);
    wait_until(u + 241);
    check("stb_low_mid_frame", stb, 0);
    #2 rst = 1'b1;
    exp_b.delete();
    exp_d.delete();
    #1;
    check("midrst_clk", clk, 1);
    check("midrst_stb", stb, 1);
    check("midrst_dio", dio, 1);
    check("midrst_busy", busy, 0);
    @(negedge sclk);
    @(negedge sclk);
    #2 rst = 1'b0;

    // Clean frame after reset, then update coincident with DONE
    pulse(32'h2468ACE0, 3'd6, u);
    push_frame(32'h2468ACE0, 3'd6, u + 621);
    wait_until(u + 621);
    digits = 32'h13579BDF;
    brightness = 3'd1;
    update = 1'b1;
    @(negedge sclk);
    update = 1'b0;
    push_frame(32'h13579BDF, 3'd1, u + 622 + 621);
    wait_until(u + 1260);

    repeat (1500) @(negedge sclk);
    check("bytes_left", exp_b.size(), 0);
    check("dones_left", exp_d.size(), 0);
    check("dio_stable_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
